id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, a flush path and saturating stall/flush counters.
// Latency: one clock from ID inputs to EX outputs. Stall and Hazard are combinational in the same cycle.
// Backpressure: Stall holds PC and IF/ID for one cycle while a bubble enters EX. Flush overrides Stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IDValid,
    input  logic [5:0]  CtrlIn,
    input  logic [1:0]  ALUOpIn,
    input  logic [31:0] ReadData1In,
    input  logic [31:0] ReadData2In,
    input  logic [31:0] SignExtIn,
    input  logic [4:0]  RsIn,
    input  logic [4:0]  RtIn,
    input  logic [4:0]  RdIn,
    input  logic        UsesRs,
    input  logic        UsesRt,
    input  logic        Flush,
    output logic [5:0]  CtrlOut,
    output logic [1:0]  ALUOp,
    output logic [5:0]  FuncCode,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] SignExt,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic        EXValid,
    output logic        Stall,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    // Control bit order is {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst}.
    localparam int MEMREAD_BIT = 3;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [1:0]  aluop;
        logic [5:0]  func;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    idex_t       w_id;
    idex_t       r_ex;
    logic        r_valid;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_hazard;
    logic        w_stall;
    logic        w_load;
    logic        w_flush_evt;

    // Pack the ID-stage fields into one payload; the function code is the low six immediate bits.
    always_comb begin
        w_id       = '0;
        w_id.ctrl  = CtrlIn;
        w_id.aluop = ALUOpIn;
        w_id.func  = SignExtIn[5:0];
        w_id.rd1   = ReadData1In;
        w_id.rd2   = ReadData2In;
        w_id.sext  = SignExtIn;
        w_id.rs    = RsIn;
        w_id.rt    = RtIn;
        w_id.rd    = RdIn;
    end

    // Load-use detection: a real load in EX whose non-zero target is read by the ID instruction.
    // Because the inserted bubble clears EXValid, the hazard can last at most one cycle.
    always_comb begin
        w_hazard    = r_valid & r_ex.ctrl[MEMREAD_BIT] & (r_ex.rt != 5'd0) &
                      ((UsesRs & (RsIn == r_ex.rt)) | (UsesRt & (RtIn == r_ex.rt)));
        w_stall     = IDValid & ~Flush & w_hazard;
        w_load      = IDValid & ~Flush & ~w_hazard;
        w_flush_evt = IDValid & Flush;
    end

    // Pipeline register: load the ID payload, otherwise insert an all-zero bubble (no writes, ALUOp add).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_ex    <= w_id;
            r_valid <= 1'b1;
        end else begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end
    end

    // Saturating event counters for stall cycles and flushes of real instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign CtrlOut    = r_ex.ctrl;
    assign ALUOp      = r_ex.aluop;
    assign FuncCode   = r_ex.func;
    assign ReadData1  = r_ex.rd1;
    assign ReadData2  = r_ex.rd2;
    assign SignExt    = r_ex.sext;
    assign Rs         = r_ex.rs;
    assign Rt         = r_ex.rt;
    assign Rd         = r_ex.rd;
    assign EXValid    = r_valid;
    assign Stall      = w_stall;
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [5:0] C_LW   = 6'b111010;
    localparam logic [5:0] C_RTYP = 6'b100001;
    localparam logic [5:0] C_OTH  = 6'b100010;

    logic        clk;
    logic        rst_n;
    logic        IDValid;
    logic [5:0]  CtrlIn;
    logic [1:0]  ALUOpIn;
    logic [31:0] ReadData1In, ReadData2In, SignExtIn;
    logic [4:0]  RsIn, RtIn, RdIn;
    logic        UsesRs, UsesRt, Flush;
    logic [5:0]  CtrlOut;
    logic [1:0]  ALUOp;
    logic [5:0]  FuncCode;
    logic [31:0] ReadData1, ReadData2, SignExt;
    logic [4:0]  Rs, Rt, Rd;
    logic        EXValid, Stall;
    logic [15:0] StallCount, FlushCount;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .IDValid(IDValid), .CtrlIn(CtrlIn), .ALUOpIn(ALUOpIn),
        .ReadData1In(ReadData1In), .ReadData2In(ReadData2In), .SignExtIn(SignExtIn),
        .RsIn(RsIn), .RtIn(RtIn), .RdIn(RdIn), .UsesRs(UsesRs), .UsesRt(UsesRt), .Flush(Flush),
        .CtrlOut(CtrlOut), .ALUOp(ALUOp), .FuncCode(FuncCode),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExt(SignExt),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .EXValid(EXValid), .Stall(Stall),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] c, input logic [1:0] op,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] se,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic ur, input logic ut, input logic fl);
        IDValid = v; CtrlIn = c; ALUOpIn = op;
        ReadData1In = d1; ReadData2In = d2; SignExtIn = se;
        RsIn = s; RtIn = t; RdIn = d; UsesRs = ur; UsesRt = ut; Flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Puts a lw with target register t into EX.
    task automatic load_lw(input logic [4:0] t);
        @(negedge clk);
        drive(1'b1, C_LW, 2'b00, 32'h0000_1000, 32'h0, 32'h10, 5'd4, t, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 6'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        check("reset_exvalid", {31'd0, EXValid}, 32'd0);
        check("reset_ctrl", {26'd0, CtrlOut}, 32'd0);
        check("reset_stallcnt", {16'd0, StallCount}, 32'd0);
        check("reset_flushcnt", {16'd0, FlushCount}, 32'd0);
        check("reset_stall", {31'd0, Stall}, 32'd0);

        // R-type passes straight through with one cycle of latency.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, C_RTYP, 2'b10, 32'h1111_0000, 32'h0000_2222, 32'h0000_002A,
              5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        #1 check("rtype_nostall", {31'd0, Stall}, 32'd0);
        tick();
        check("rtype_aluop", {30'd0, ALUOp}, 32'd2);
        check("rtype_func", {26'd0, FuncCode}, 32'h2A);
        check("rtype_ctrl", {26'd0, CtrlOut}, 32'h21);
        check("rtype_valid", {31'd0, EXValid}, 32'd1);
        check("rtype_rd1", ReadData1, 32'h1111_0000);
        check("rtype_rd2", ReadData2, 32'h0000_2222);
        check("rtype_sext", SignExt, 32'h0000_002A);
        check("rtype_regs", {17'd0, Rs, Rt, Rd}, {17'd0, 5'd1, 5'd2, 5'd3});

        // Load-use on Rs: one stall cycle, a bubble, then the add loads.
        load_lw(5'd8);
        check("lw_ctrl", {26'd0, CtrlOut}, {26'd0, C_LW});
        check("lw_rt", {27'd0, Rt}, 32'd8);
        @(negedge clk);
        drive(1'b1, C_RTYP, 2'b10, 32'h5, 32'h6, 32'h20, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0);
        #1 check("lu_stall", {31'd0, Stall}, 32'd1);
        tick();
        check("lu_bubble_valid", {31'd0, EXValid}, 32'd0);
        check("lu_bubble_ctrl", {26'd0, CtrlOut}, 32'd0);
        check("lu_bubble_aluop", {30'd0, ALUOp}, 32'd0);
        check("lu_bubble_rd1", ReadData1, 32'd0);
        check("lu_bubble_rd", {27'd0, Rd}, 32'd0);
        check("lu_stallcnt", {16'd0, StallCount}, 32'd1);
        check("lu_stall_drops", {31'd0, Stall}, 32'd0);
        tick();
        check("lu_add_valid", {31'd0, EXValid}, 32'd1);
        check("lu_add_rd", {27'd0, Rd}, 32'd10);
        check("lu_stallcnt_hold", {16'd0, StallCount}, 32'd1);

        // Rt matches the load target but the instruction does not read Rt: no stall.
        load_lw(5'd8);
        @(negedge clk);
        drive(1'b1, C_OTH, 2'b00, 32'h7, 32'h8, 32'h4, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("unused_rt_nostall", {31'd0, Stall}, 32'd0);
        tick();
        check("unused_rt_valid", {31'd0, EXValid}, 32'd1);

        // Rt = 0 is never a hazard.
        load_lw(5'd0);
        @(negedge clk);
        drive(1'b1, C_RTYP, 2'b10, 32'h1, 32'h2, 32'h20, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0);
        #1 check("zero_nostall", {31'd0, Stall}, 32'd0);
        tick();
        check("zero_valid", {31'd0, EXValid}, 32'd1);
        check("zero_stallcnt", {16'd0, StallCount}, 32'd1);

        // Hazard and Flush together: flush only.
        load_lw(5'd8);
        @(negedge clk);
        drive(1'b1, C_RTYP, 2'b10, 32'h1, 32'h2, 32'h20, 5'd8, 5'd1, 5'd12, 1'b1, 1'b1, 1'b1);
        #1 check("flush_nostall", {31'd0, Stall}, 32'd0);
        tick();
        check("flush_bubble", {31'd0, EXValid}, 32'd0);
        check("flush_ctrl", {26'd0, CtrlOut}, 32'd0);
        check("flush_cnt", {16'd0, FlushCount}, 32'd1);
        check("flush_stallcnt", {16'd0, StallCount}, 32'd1);

        // Flush without a real ID instruction is not counted.
        @(negedge clk);
        drive(1'b0, C_RTYP, 2'b10, 32'h1, 32'h2, 32'h20, 5'd1, 5'd1, 5'd12, 1'b0, 1'b0, 1'b1);
        tick();
        check("flush_invalid_cnt", {16'd0, FlushCount}, 32'd1);
        check("flush_invalid_bubble", {31'd0, EXValid}, 32'd0);

        // Stall counter saturation: preset near the top, then stall three times.
        @(negedge clk);
        drive(1'b0, 6'd0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        force dut.r_stall_cnt = 16'hFFFE;
        #1 release dut.r_stall_cnt;
        #1 check("sat_preset", {16'd0, StallCount}, 32'h0000_FFFE);
        @(negedge clk);
        drive(1'b1, C_LW, 2'b00, 32'h0, 32'h0, 32'h4, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #3 check("sat_stall_asserted", {31'd0, Stall}, 32'd1);
            tick();
            if (i == 0) check("sat_first", {16'd0, StallCount}, 32'h0000_FFFF);
        end
        check("sat_hold", {16'd0, StallCount}, 32'h0000_FFFF);

        // Asynchronous reset in the middle of a stall cycle.
        tick();
        @(negedge clk);
        drive(1'b1, C_RTYP, 2'b10, 32'hA, 32'hB, 32'h2A, 5'd8, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0);
        #1 check("pre_reset_stall", {31'd0, Stall}, 32'd1);
        check("pre_reset_valid", {31'd0, EXValid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, EXValid}, 32'd0);
        check("areset_ctrl", {26'd0, CtrlOut}, 32'd0);
        check("areset_rt", {27'd0, Rt}, 32'd0);
        check("areset_stall", {31'd0, Stall}, 32'd0);
        check("areset_stallcnt", {16'd0, StallCount}, 32'd0);
        check("areset_flushcnt", {16'd0, FlushCount}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_valid", {31'd0, EXValid}, 32'd1);
        check("post_reset_rd", {27'd0, Rd}, 32'd13);
        check("post_reset_stallcnt", {16'd0, StallCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
